eq_stream_checker: RTL and testbench
====================================

# eq_stream_checker

Parametrised equivalence-checking harness that runs two stream-interfaced model instances (A, high-level; B, detailed) side by side from one shared input stream and compares their output streams token by token. Per-side FIFOs absorb latency differences between the models. Step enables replace gated clocks for model stalling. A phase FSM, a bounded cycle counter and sticky verdict flags give the property checker a single observable result.

## Interface
- DATA_W, 8, width of output tokens from both models
- FIFO_DEPTH, 4, entries per side FIFO (power of two, >= 2)
- CNT_W, 16, width of cycle and token counters
- MAX_CYCLES, 15, RUN-phase cycle bound before timeout (< 2^CNT_W)
- clk  in  1  single clock; both models run on it
- rst_init  in  1  synchronous, active-high reset
- a_complete, b_complete  in  1  model reports end of its computation (level)
- a_tdata / b_tdata  in  DATA_W  model output token
- a_tvalid / b_tvalid  in  1  model output valid
- a_tready / b_tready  out  1  checker ready to accept a model token
- a_step / b_step  out  1  model step enable (stall when 0)
- phase  out  2  0 RUN, 1 DRAIN, 2 DONE
- mismatch  out  1  sticky: some compared pair differed
- len_mismatch  out  1  sticky: token counts differ at end
- timeout  out  1  sticky: MAX_CYCLES reached in RUN
- mm_idx  out  CNT_W  index of first mismatching pair
- mm_a_data / mm_b_data  out  DATA_W  values of first mismatching pair
- tok_cnt  out  CNT_W  pairs compared so far (saturating)

## Operation
- Reset: every register and output 0; phase RUN; step and tready forced 0 while rst_init high.
- Push: token enters side FIFO on tvalid & tready; tready = ~full (no full-bypass).
- Compare: when both FIFOs non-empty, pop one from each in the same cycle; tok_cnt increments, saturating at 2^CNT_W-1.
- First differing pair: mismatch set, mm_idx = tok_cnt before increment, data captured; later mismatches leave captures unchanged.
- a_done/b_done latch on a_complete/b_complete, cleared only by reset.
- a_step = (phase==RUN) & ~a_done & ~a_full; b_step symmetric.
- Cycle counter counts in RUN only, saturates at MAX_CYCLES.
- FSM: RUN -> DRAIN when a_done & b_done; RUN -> DONE with timeout=1 when counter == MAX_CYCLES and not both done (done wins if same cycle).
- DRAIN: pairs keep popping; when either FIFO empty and no pop this cycle -> DONE; len_mismatch = other FIFO non-empty.
- DONE: absorbing; no push, no pop, no steps; flags frozen.

## Timing
- Token accepted at edge N compared no earlier than edge N+1 (FIFO registered output).
- mismatch, mm_* and tok_cnt update at the edge of the pop.
- Simultaneous push and pop on one FIFO allowed at any fill level except push when full.
- a_complete pulse of one cycle is sufficient; phase reaches DRAIN one edge after both latched.
- Reset mid-run clears all flags and FIFOs at the next edge; models must be reset externally in the same cycle.

## Configuration
- EQ_CHK_TRACE_EN defined: mm_idx, mm_a_data, mm_b_data captured as above.
- Not defined: capture registers omitted; those ports driven constant 0; mismatch, len_mismatch, timeout, tok_cnt unchanged.

## Structure
- Package eq_chk_pkg: phase encoding constants (PH_RUN, PH_DRAIN, PH_DONE) and phase typedef.
- Sub-module eq_sync_fifo (DATA_W, FIFO_DEPTH): push/pop/full/empty/dout, instantiated once per side.
- Top owns FSM, counters, compare and capture logic.

## Test plan
- Identical streams 0x11,0x22,0x33 from both sides, A two cycles ahead of B; both complete -> tok_cnt=3, mismatch=0, len_mismatch=0, phase DONE.
- B emits 0x11,0x2F,0x33 vs A 0x11,0x22,0x33 -> mismatch=1, mm_idx=1, mm_a_data=0x22, mm_b_data=0x2F (0s without EQ_CHK_TRACE_EN).
- A emits 5 tokens while B silent, FIFO_DEPTH=4 -> a_tready and a_step low after 4th push; resume after B supplies tokens.
- A emits 3, B emits 2, both complete -> DRAIN pops 2, DONE with len_mismatch=1.
- b_complete never asserted -> timeout=1, phase DONE at cycle MAX_CYCLES=15; completion on cycle 15 instead -> DRAIN, timeout=0.
- rst_init asserted mid-DRAIN with mismatch=1 -> next edge all outputs 0, phase RUN.

Source files
------------

// File: rtl/eq_chk_pkg.sv
// ============================================================================
// Module   : eq_chk_pkg
// Brief    : Phase encoding shared by the equivalence-checking harness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eq_chk_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_RUN   = 2'd0,
    PH_DRAIN = 2'd1,
    PH_DONE  = 2'd2
  } phase_t;

endpackage

`default_nettype wire

// File: rtl/eq_sync_fifo.sv
// ============================================================================
// Module   : eq_sync_fifo
// Brief    : Single-clock FIFO; output word is a registered memory read, so
//            a word pushed at one edge is first poppable at the next.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] dout_o
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [c_addr_w-1:0] wr_ptr_q;
  logic [c_addr_w-1:0] rd_ptr_q;
  logic [c_addr_w:0]   count_q;
  logic                w_push;
  logic                w_pop;

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // Power-of-two depth lets the pointers wrap naturally; count tracks fill.
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/eq_stream_checker.sv
// ============================================================================
// Module   : eq_stream_checker
// Brief    : Runs two model output streams into per-side FIFOs and compares
//            them pairwise; phase FSM, cycle bound and sticky verdict flags.
//            Define EQ_CHK_TRACE_EN to capture the first mismatching pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_stream_checker #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_init,
  input  logic              a_complete,
  input  logic              b_complete,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic [DATA_W-1:0] b_tdata,
  input  logic              a_tvalid,
  input  logic              b_tvalid,
  output logic              a_tready,
  output logic              b_tready,
  output logic              a_step,
  output logic              b_step,
  output logic [1:0]        phase,
  output logic              mismatch,
  output logic              len_mismatch,
  output logic              timeout,
  output logic [CNT_W-1:0]  mm_idx,
  output logic [DATA_W-1:0] mm_a_data,
  output logic [DATA_W-1:0] mm_b_data,
  output logic [CNT_W-1:0]  tok_cnt
);

  import eq_chk_pkg::*;

  localparam logic [CNT_W-1:0] c_max_cyc = CNT_W'(MAX_CYCLES);

  phase_t             phase_q;
  logic               a_done_q;
  logic               b_done_q;
  logic [CNT_W-1:0]   cyc_q;
  logic [CNT_W-1:0]   tok_cnt_q;
  logic [CNT_W-1:0]   tok_cnt_d;
  logic               mismatch_q;
  logic               len_mm_q;
  logic               timeout_q;

  logic               w_a_full;
  logic               w_a_empty;
  logic [DATA_W-1:0]  w_a_dout;
  logic               w_b_full;
  logic               w_b_empty;
  logic [DATA_W-1:0]  w_b_dout;
  logic               w_live;
  logic               w_a_push;
  logic               w_b_push;
  logic               w_pop;
  logic               w_diff;

  // Anything that moves data is frozen in DONE and while reset is held.
  assign w_live   = ~rst_init & (phase_q != PH_DONE);
  assign a_tready = w_live & ~w_a_full;
  assign b_tready = w_live & ~w_b_full;
  assign w_a_push = a_tvalid & a_tready;
  assign w_b_push = b_tvalid & b_tready;
  assign w_pop    = w_live & ~w_a_empty & ~w_b_empty;
  assign w_diff   = (w_a_dout != w_b_dout);

  assign a_step = ~rst_init & (phase_q == PH_RUN) & ~a_done_q & ~w_a_full;
  assign b_step = ~rst_init & (phase_q == PH_RUN) & ~b_done_q & ~w_b_full;

  assign tok_cnt_d = (tok_cnt_q != '1) ? tok_cnt_q + 1'b1 : tok_cnt_q;

  eq_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst_init),
    .push_i  (w_a_push),
    .din_i   (a_tdata),
    .pop_i   (w_pop),
    .full_o  (w_a_full),
    .empty_o (w_a_empty),
    .dout_o  (w_a_dout)
  );

  eq_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst_init),
    .push_i  (w_b_push),
    .din_i   (b_tdata),
    .pop_i   (w_pop),
    .full_o  (w_b_full),
    .empty_o (w_b_empty),
    .dout_o  (w_b_dout)
  );

  always_ff @(posedge clk) begin
    if (rst_init) begin
      phase_q    <= PH_RUN;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      cyc_q      <= '0;
      tok_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      len_mm_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      a_done_q <= a_done_q | a_complete;
      b_done_q <= b_done_q | b_complete;
      if (w_pop) begin
        tok_cnt_q <= tok_cnt_d;
        if (w_diff) begin
          mismatch_q <= 1'b1;
        end
      end
      case (phase_q)
        PH_RUN: begin
          if (cyc_q != c_max_cyc) begin
            cyc_q <= cyc_q + 1'b1;
          end
          // Completion takes priority over a timeout hitting on the same edge.
          if (a_done_q & b_done_q) begin
            phase_q <= PH_DRAIN;
          end else if (cyc_q == c_max_cyc) begin
            phase_q   <= PH_DONE;
            timeout_q <= 1'b1;
          end
        end
        PH_DRAIN: begin
          if (w_a_empty | w_b_empty) begin
            phase_q  <= PH_DONE;
            len_mm_q <= ~w_a_empty | ~w_b_empty;
          end
        end
        default: phase_q <= phase_q;
      endcase
    end
  end

  assign phase        = phase_q;
  assign mismatch     = mismatch_q;
  assign len_mismatch = len_mm_q;
  assign timeout      = timeout_q;
  assign tok_cnt      = tok_cnt_q;

`ifdef EQ_CHK_TRACE_EN
  logic [CNT_W-1:0]  mm_idx_q;
  logic [DATA_W-1:0] mm_a_q;
  logic [DATA_W-1:0] mm_b_q;

  always_ff @(posedge clk) begin
    if (rst_init) begin
      mm_idx_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else if (w_pop & w_diff & ~mismatch_q) begin
      mm_idx_q <= tok_cnt_q;
      mm_a_q   <= w_a_dout;
      mm_b_q   <= w_b_dout;
    end
  end

  assign mm_idx    = mm_idx_q;
  assign mm_a_data = mm_a_q;
  assign mm_b_data = mm_b_q;
`else
  assign mm_idx    = '0;
  assign mm_a_data = '0;
  assign mm_b_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eq_stream_checker.sv
// ============================================================================
// Module   : tb_eq_stream_checker
// Brief    : Directed scoreboard bench for eq_stream_checker; final verdicts
//            are queued by the stimulus and checked when phase enters DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eq_stream_checker;

  logic        clk = 1'b0;
  logic        rst_init;
  logic        a_complete, b_complete;
  logic [7:0]  a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid;
  logic        a_tready, b_tready;
  logic        a_step, b_step;
  logic [1:0]  phase;
  logic        mismatch, len_mismatch, timeout;
  logic [15:0] mm_idx;
  logic [7:0]  mm_a_data, mm_b_data;
  logic [15:0] tok_cnt;

`ifdef EQ_CHK_TRACE_EN
  localparam bit c_trace = 1'b1;
`else
  localparam bit c_trace = 1'b0;
`endif

  typedef struct {
    logic [15:0] tok;
    logic        mm;
    logic        lm;
    logic        to;
    logic [15:0] idx;
    logic [7:0]  ad;
    logic [7:0]  bd;
  } verdict_t;

  verdict_t   exp_q[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] mon_prev = 2'd0;

  eq_stream_checker #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .CNT_W      (16),
    .MAX_CYCLES (15)
  ) dut (
    .clk          (clk),
    .rst_init     (rst_init),
    .a_complete   (a_complete),
    .b_complete   (b_complete),
    .a_tdata      (a_tdata),
    .b_tdata      (b_tdata),
    .a_tvalid     (a_tvalid),
    .b_tvalid     (b_tvalid),
    .a_tready     (a_tready),
    .b_tready     (b_tready),
    .a_step       (a_step),
    .b_step       (b_step),
    .phase        (phase),
    .mismatch     (mismatch),
    .len_mismatch (len_mismatch),
    .timeout      (timeout),
    .mm_idx       (mm_idx),
    .mm_a_data    (mm_a_data),
    .mm_b_data    (mm_b_data),
    .tok_cnt      (tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_verdict(input logic [15:0] tok, input logic mm, input logic lm,
                              input logic to, input logic [15:0] idx,
                              input logic [7:0] ad, input logic [7:0] bd);
    verdict_t v;
    v.tok = tok; v.mm = mm; v.lm = lm; v.to = to;
    v.idx = c_trace ? idx : 16'h0;
    v.ad  = c_trace ? ad  : 8'h0;
    v.bd  = c_trace ? bd  : 8'h0;
    exp_q.push_back(v);
  endtask

  // Monitor: a verdict is presented each time phase enters DONE.
  initial begin
    verdict_t e;
    forever begin
      @(negedge clk);
      if (phase == 2'd2 && mon_prev != 2'd2) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: phase reached DONE with no verdict queued (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("verdict.tok_cnt",      tok_cnt,      e.tok);
          chk("verdict.mismatch",     mismatch,     e.mm);
          chk("verdict.len_mismatch", len_mismatch, e.lm);
          chk("verdict.timeout",      timeout,      e.to);
          chk("verdict.mm_idx",       mm_idx,       e.idx);
          chk("verdict.mm_a_data",    mm_a_data,    e.ad);
          chk("verdict.mm_b_data",    mm_b_data,    e.bd);
        end
      end
      mon_prev = phase;
    end
  end

  task automatic send_a(input int dly);
    int budget = 0;
    repeat (dly + 1) @(posedge clk);
    #1;
    while (qa.size() > 0 && budget < 60) begin
      a_tvalid = 1'b1;
      a_tdata  = qa[0];
      @(negedge clk);
      if (a_tready) void'(qa.pop_front());
      @(posedge clk); #1;
      budget++;
    end
    a_tvalid = 1'b0;
    if (qa.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL send_a: %0d tokens left unaccepted, expected 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic send_b(input int dly);
    int budget = 0;
    repeat (dly + 1) @(posedge clk);
    #1;
    while (qb.size() > 0 && budget < 60) begin
      b_tvalid = 1'b1;
      b_tdata  = qb[0];
      @(negedge clk);
      if (b_tready) void'(qb.pop_front());
      @(posedge clk); #1;
      budget++;
    end
    b_tvalid = 1'b0;
    if (qb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL send_b: %0d tokens left unaccepted, expected 0", qb.size());
      qb.delete();
    end
  endtask

  task automatic run_a(input int dly);
    send_a(dly);
    a_complete = 1'b1;
    @(posedge clk); #1;
    a_complete = 1'b0;
  endtask

  task automatic run_b(input int dly);
    send_b(dly);
    b_complete = 1'b1;
    @(posedge clk); #1;
    b_complete = 1'b0;
  endtask

  task automatic do_reset();
    rst_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_init = 1'b0;
  endtask

  task automatic wait_verdict(input string name);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: DONE not reached within budget, %0d verdicts pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_init = 1'b1;
    a_complete = 1'b0; b_complete = 1'b0;
    a_tdata = 8'h0; b_tdata = 8'h0;
    a_tvalid = 1'b0; b_tvalid = 1'b0;

    // Reset state while rst_init is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.phase", phase, 2'd0);
    chk("rst.a_tready", a_tready, 1'b0);
    chk("rst.b_step", b_step, 1'b0);
    chk("rst.a_step", a_step, 1'b0);
    chk("rst.mismatch", mismatch, 1'b0);
    chk("rst.tok_cnt", tok_cnt, 16'd0);
    chk("rst.timeout", timeout, 1'b0);
    chk("rst.mm_idx", mm_idx, 16'd0);
    @(posedge clk); #1 rst_init = 1'b0;
    @(negedge clk);
    chk("run.a_tready", a_tready, 1'b1);
    chk("run.a_step", a_step, 1'b1);

    // 1: identical streams, A two cycles ahead of B.
    do_reset();
    qa = '{8'h11, 8'h22, 8'h33};
    qb = '{8'h11, 8'h22, 8'h33};
    push_verdict(16'd3, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00);
    fork run_a(0); run_b(2); join
    wait_verdict("identical");

    // 2: second pair differs.
    do_reset();
    qa = '{8'h11, 8'h22, 8'h33};
    qb = '{8'h11, 8'h2F, 8'h33};
    push_verdict(16'd3, 1'b1, 1'b0, 1'b0, 16'd1, 8'h22, 8'h2F);
    fork run_a(0); run_b(2); join
    wait_verdict("mismatch");

    // 3: A fills its FIFO while B is silent, then B catches up.
    do_reset();
    qa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    qb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_verdict(16'd5, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00);
    fork run_a(0); join_none
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp.a_tready_3", a_tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp.a_tready_full", a_tready, 1'b0);
    chk("bp.a_step_full", a_step, 1'b0);
    chk("bp.b_step", b_step, 1'b1);
    fork run_b(0); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp.a_tready_resume", a_tready, 1'b1);
    wait_verdict("backpressure");

    // 4: A emits one more token than B.
    do_reset();
    qa = '{8'h01, 8'h02, 8'h03};
    qb = '{8'h01, 8'h02};
    push_verdict(16'd2, 1'b0, 1'b1, 1'b0, 16'd0, 8'h00, 8'h00);
    fork run_a(0); run_b(0); join
    wait_verdict("len_mismatch");

    // 5: B never completes; timeout fires on the edge after the counter hits 15.
    do_reset();
    qa = '{8'h7A};
    qb = '{8'h7A};
    push_verdict(16'd1, 1'b0, 1'b0, 1'b1, 16'd0, 8'h00, 8'h00);
    fork run_a(0); send_b(0); join_none
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("to.phase_before", phase, 2'd0);
    @(posedge clk);
    @(negedge clk);
    chk("to.phase_after", phase, 2'd2);
    chk("to.timeout", timeout, 1'b1);
    chk("to.a_step_done", a_step, 1'b0);
    wait_verdict("timeout");

    // 5b: both completions latch on the edge the counter reaches 15.
    do_reset();
    push_verdict(16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00);
    repeat (14) @(posedge clk);
    #1 a_complete = 1'b1; b_complete = 1'b1;
    @(posedge clk);
    #1 a_complete = 1'b0; b_complete = 1'b0;
    @(negedge clk);
    chk("late.phase_run", phase, 2'd0);
    @(posedge clk);
    @(negedge clk);
    chk("late.phase_drain", phase, 2'd1);
    chk("late.timeout", timeout, 1'b0);
    wait_verdict("late_complete");

    // 6: reset asserted while in DRAIN with a mismatch recorded.
    do_reset();
    qa = '{8'h11, 8'h22, 8'h33};
    qb = '{8'h11, 8'h2F, 8'h33};
    fork run_a(0); run_b(2); join
    for (int i = 0; i < 40 && phase != 2'd1; i++) @(negedge clk);
    chk("mid.phase_drain", phase, 2'd1);
    chk("mid.mismatch", mismatch, 1'b1);
    rst_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid.rst_phase", phase, 2'd0);
    chk("mid.rst_mismatch", mismatch, 1'b0);
    chk("mid.rst_tok_cnt", tok_cnt, 16'd0);
    chk("mid.rst_mm_a", mm_a_data, 8'h00);
    chk("mid.rst_tready", b_tready, 1'b0);
    #1 rst_init = 1'b0;
    @(negedge clk);
    chk("mid.run_b_step", b_step, 1'b1);
    chk("mid.run_len_mm", len_mismatch, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
